mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28: line (block) address width.
REQ-002 Parameter LINE_W, default 128: cache line data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ic_req  in  1  I-cache miss read request, level, held until ic_ready.
REQ-006 ic_addr  in  ADDR_W  I-cache line address, stable while ic_req.
REQ-007 ic_ready  out  1  one-cycle pulse: I-cache transaction complete.
REQ-008 ic_rdata  out  LINE_W  returned line, valid only while ic_ready.
REQ-009 dc_req  in  1  D-cache request, level, held until dc_ready.
REQ-010 dc_wen  in  1  1=write-back line, 0=line fill read; stable while dc_req.
REQ-011 dc_addr  in  ADDR_W  D-cache line address, stable while dc_req.
REQ-012 dc_wdata  in  LINE_W  write-back line, stable while dc_req.
REQ-013 dc_ready  out  1  one-cycle pulse: D-cache transaction complete.
REQ-014 dc_rdata  out  LINE_W  returned line, valid only while dc_ready and dc_wen=0.
REQ-015 mem_read  out  1  memory read strobe, held until mem_ready.
REQ-016 mem_write  out  1  memory write strobe, held until mem_ready.
REQ-017 mem_addr  out  ADDR_W  memory line address.
REQ-018 mem_wdata  out  LINE_W  memory write data.
REQ-019 mem_rdata  in  LINE_W  memory read data, valid with mem_ready.
REQ-020 mem_ready  in  1  memory completion, sampled only in SERVE_I/SERVE_D.

Function
REQ-021 FSM states SHALL be IDLE, SERVE_I, SERVE_D, RESP; at most one memory transaction outstanding.
REQ-022 IDLE, only ic_req=1 -> SERVE_I; only dc_req=1 -> SERVE_D; neither -> stay IDLE.
REQ-023 IDLE, both requests high -> grant the requester NOT in register last_grant (round-robin); last_grant updated on every grant.
REQ-024 On grant edge: mem_addr/mem_wdata SHALL be registered from the granted requester; mem_read=1 for I or D-read, mem_write=1 for D-write.
REQ-025 In SERVE_*: mem_read/mem_write/mem_addr/mem_wdata SHALL be held constant; request input changes ignored.
REQ-026 SERVE_*, mem_ready=1 at edge -> capture mem_rdata into response register, deassert mem_read/mem_write, go RESP.
REQ-027 RESP lasts exactly one cycle: ready of the served requester =1, other ready =0; then IDLE unconditionally.
REQ-028 ic_rdata and dc_rdata SHALL both be driven from the response register; content outside ready is don't-care but SHALL not be X after first fill.
REQ-029 Minimum latency: req high before edge N -> mem strobe high after edge N; mem_ready at edge N+k -> ready high in cycle after edge N+k; next grant no earlier than edge N+k+2.
REQ-030 mem_ready asserted in IDLE or RESP SHALL be ignored (no state or output change).
REQ-031 No timeout: a SERVE state waits indefinitely for mem_ready.
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, last_grant=I (so D wins the first tie), mem_read=mem_write=0, ic_ready=dc_ready=0, mem_addr=0, mem_wdata=0, response register=0.
REQ-034 rst mid-transaction SHALL abort it with no ready pulse; the requester re-issues after reset release.

Verification
REQ-035 Reset release, ic_req=1 addr=0x0000010, memory replies mem_ready after 3 cycles with 0xA5..A5 -> mem_read 1 for 3 cycles, ic_ready one cycle with ic_rdata=0xA5..A5, dc_ready=0.
REQ-036 Both requests in same cycle after reset (dc_wen=1 addr=0x20) -> D served first with mem_write=1 mem_addr=0x20; I served next; each ready pulses once.
REQ-037 Both held continuously for 4 transactions -> grant order D, I, D, I; no starvation.
REQ-038 mem_ready pulsed while IDLE with no requests -> no state change, all strobes and readies stay 0.
REQ-039 rst asserted during SERVE_D -> mem_write drops asynchronously, no dc_ready; after release dc_req re-served normally.
REQ-040 dc_addr/dc_wdata changed during SERVE_D -> mem_addr/mem_wdata unchanged until transaction ends.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the
// I-cache miss path and the D-cache fill/write-back path.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_wen,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  state_t            state_q;
  state_t            state_d;
  gnt_t              last_q;
  gnt_t              last_d;
  logic              read_d;
  logic              write_d;
  logic              ic_ready_d;
  logic              dc_ready_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LINE_W-1:0] wdata_d;
  logic [LINE_W-1:0] resp_q;
  logic [LINE_W-1:0] resp_d;
  logic              pick_i;
  logic              pick_d;

  // On a tie the side that did not win last time gets the port.
  assign pick_d = dc_req & (~ic_req | (last_q == GNT_I));
  assign pick_i = ic_req & ~pick_d;

  assign ic_rdata = resp_q;
  assign dc_rdata = resp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GNT_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    read_d     = mem_read;
    write_d    = mem_write;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    resp_d     = resp_q;
    ic_ready_d = 1'b0;
    dc_ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_d: begin
            state_d = SERVE_D;
            last_d  = GNT_D;
            read_d  = ~dc_wen;
            write_d = dc_wen;
            addr_d  = dc_addr;
            wdata_d = dc_wdata;
          end
          pick_i: begin
            state_d = SERVE_I;
            last_d  = GNT_I;
            read_d  = 1'b1;
            write_d = 1'b0;
            addr_d  = ic_addr;
            wdata_d = '0;
          end
          default: ;
        endcase
      end
      SERVE_I, SERVE_D: begin
        if (mem_ready) begin
          state_d    = RESP;
          resp_d     = mem_rdata;
          read_d     = 1'b0;
          write_d    = 1'b0;
          ic_ready_d = (state_q == SERVE_I);
          dc_ready_d = (state_q == SERVE_D);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a flop; request and memory inputs only reach them here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      resp_q    <= '0;
      ic_ready  <= 1'b0;
      dc_ready  <= 1'b0;
    end else begin
      mem_read  <= read_d;
      mem_write <= write_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      resp_q    <= resp_d;
      ic_ready  <= ic_ready_d;
      dc_ready  <= dc_ready_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and a
// randomized run scored against a transaction-level reference.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_ready;
  logic [LW-1:0] ic_rdata;
  logic          dc_req;
  logic          dc_wen;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          dc_ready;
  logic [LW-1:0] dc_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_ready (ic_ready),
    .ic_rdata (ic_rdata),
    .dc_req   (dc_req),
    .dc_wen   (dc_wen),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_ready (dc_ready),
    .dc_rdata (dc_rdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // in: rst,ic,dc,wen,mrdy  ex: mem_read,mem_write,ic_ready,dc_ready
  typedef struct {
    logic [4:0]    in;
    logic [7:0]    rb;
    logic [3:0]    ex;
    logic [AW-1:0] ea;
    logic [7:0]    eb;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [LW-1:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ic_req    = 1'b0;
    dc_req    = 1'b0;
    dc_wen    = 1'b0;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Reference state for the randomized run.
  logic [LW-1:0] mem_arr[16];
  logic [LW-1:0] ref_mem[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   order[$];
    int   got;
    rst       = 1'b1;
    ic_req    = 1'b0;
    ic_addr   = '0;
    dc_req    = 1'b0;
    dc_wen    = 1'b0;
    dc_addr   = '0;
    dc_wdata  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    tbl[0]  = '{5'b10000, 8'h00, 4'b0000, 28'h0,  8'h00};
    tbl[1]  = '{5'b01000, 8'h00, 4'b1000, 28'h10, 8'h00};
    tbl[2]  = '{5'b01000, 8'h00, 4'b1000, 28'h10, 8'h00};
    tbl[3]  = '{5'b01000, 8'h00, 4'b1000, 28'h10, 8'h00};
    tbl[4]  = '{5'b01001, 8'hA5, 4'b0010, 28'h0,  8'hA5};
    tbl[5]  = '{5'b00000, 8'h00, 4'b0000, 28'h0,  8'h00};
    tbl[6]  = '{5'b00001, 8'hFF, 4'b0000, 28'h0,  8'h00};
    tbl[7]  = '{5'b00001, 8'hFF, 4'b0000, 28'h0,  8'h00};
    tbl[8]  = '{5'b10000, 8'h00, 4'b0000, 28'h0,  8'h00};
    tbl[9]  = '{5'b01110, 8'h00, 4'b0100, 28'h20, 8'h00};
    tbl[10] = '{5'b01111, 8'h00, 4'b0001, 28'h0,  8'h00};
    tbl[11] = '{5'b01000, 8'h00, 4'b0000, 28'h0,  8'h00};
    tbl[12] = '{5'b01000, 8'h00, 4'b1000, 28'h10, 8'h00};
    tbl[13] = '{5'b01001, 8'h3C, 4'b0010, 28'h0,  8'h3C};
    tbl[14] = '{5'b00000, 8'h00, 4'b0000, 28'h0,  8'h00};

    // Vector table
    ic_addr  = 28'h10;
    dc_addr  = 28'h20;
    dc_wdata = rep(8'h5A);
    for (int i = 0; i < 15; i++) begin
      v         = tbl[i];
      rst       = v.in[4];
      ic_req    = v.in[3];
      dc_req    = v.in[2];
      dc_wen    = v.in[1];
      mem_ready = v.in[0];
      mem_rdata = rep(v.rb);
      tick();
      check($sformatf("t%0d_mem_read", i), mem_read, v.ex[3]);
      check($sformatf("t%0d_mem_write", i), mem_write, v.ex[2]);
      check($sformatf("t%0d_ic_ready", i), ic_ready, v.ex[1]);
      check($sformatf("t%0d_dc_ready", i), dc_ready, v.ex[0]);
      if (v.ex[3] | v.ex[2])
        check($sformatf("t%0d_mem_addr", i), mem_addr, v.ea);
      if (v.ex[2])
        check($sformatf("t%0d_mem_wdata", i), mem_wdata, rep(8'h5A));
      if (v.ex[1])
        check($sformatf("t%0d_ic_rdata", i), ic_rdata, rep(v.eb));
    end

    // Both held continuously: grants must alternate starting with D
    do_reset();
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    dc_wen  = 1'b0;
    ic_addr = 28'h44;
    dc_addr = 28'h55;
    got     = 0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      tick();
      if (ic_ready) order.push_back(1);
      if (dc_ready) order.push_back(2);
      mem_ready = mem_read | mem_write;
      mem_rdata = rep(8'(c));
    end
    ic_req    = 1'b0;
    dc_req    = 1'b0;
    mem_ready = 1'b0;
    check("rr_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size() && k < 4; k++)
      check($sformatf("rr_order%0d", k), 32'(order[k]),
            (k % 2 == 0) ? 32'd2 : 32'd1);

    // Write-back held stable, then aborted by reset, then re-served
    do_reset();
    tick();
    dc_req   = 1'b1;
    dc_wen   = 1'b1;
    dc_addr  = 28'h30;
    dc_wdata = rep(8'hC3);
    tick();
    check("wb_write", mem_write, 1'b1);
    check("wb_addr", mem_addr, 28'h30);
    dc_addr  = 28'h31;
    dc_wdata = rep(8'h11);
    tick();
    tick();
    check("hold_write", mem_write, 1'b1);
    check("hold_addr", mem_addr, 28'h30);
    check("hold_wdata", mem_wdata, rep(8'hC3));
    #2;
    rst = 1'b1;
    #1;
    check("async_write", mem_write, 1'b0);
    check("async_addr", mem_addr, 28'h0);
    check("async_dc_ready", dc_ready, 1'b0);
    tick();
    check("rst_dc_ready", dc_ready, 1'b0);
    dc_addr  = 28'h30;
    dc_wdata = rep(8'hC3);
    rst      = 1'b0;
    tick();
    check("reissue_write", mem_write, 1'b1);
    check("reissue_addr", mem_addr, 28'h30);
    check("reissue_dc_ready", dc_ready, 1'b0);
    mem_ready = 1'b1;
    tick();
    check("reissue_done", dc_ready, 1'b1);
    check("reissue_wdrop", mem_write, 1'b0);
    mem_ready = 1'b0;
    dc_req    = 1'b0;
    tick();
    check("reissue_pulse", dc_ready, 1'b0);

    // Randomized run against a transaction-level reference
    begin
      int            cyc;
      int            next_ok;
      int            owner;
      int            last;
      int            win;
      logic          x_wr;
      logic [AW-1:0] x_addr;
      logic [LW-1:0] x_wdata;
      logic          e_ir;
      logic          e_dr;
      logic          p_ic;
      logic          p_dc;
      logic          p_dwen;
      logic          p_mrdy;
      logic [AW-1:0] p_iaddr;
      logic [AW-1:0] p_daddr;
      logic [LW-1:0] p_dwdata;
      for (int k = 0; k < 16; k++) begin
        mem_arr[k] = {4{32'h1000_0000 + 32'(k)}};
        ref_mem[k] = mem_arr[k];
      end
      do_reset();
      cyc     = 0;
      next_ok = 0;
      owner   = 0;
      last    = 1;
      x_wr    = 1'b0;
      x_addr  = '0;
      x_wdata = '0;
      for (int n = 0; n < 3000; n++) begin
        if (mem_read | mem_write) begin
          mem_ready = ($urandom_range(0, 2) == 0);
          mem_rdata = mem_ready ? mem_arr[mem_addr[3:0]] : {4{$urandom}};
          if (mem_ready && mem_write)
            mem_arr[mem_addr[3:0]] = mem_wdata;
        end else begin
          mem_ready = ($urandom_range(0, 3) == 0);
          mem_rdata = {4{$urandom}};
        end
        if (ic_ready) begin
          ic_req = ($urandom_range(0, 1) == 1);
          ic_addr = 28'($urandom_range(0, 15));
        end else if (!ic_req) begin
          ic_req  = ($urandom_range(0, 2) == 0);
          ic_addr = 28'($urandom_range(0, 15));
        end else if (owner == 1 && $urandom_range(0, 3) == 0) begin
          ic_addr = 28'($urandom_range(0, 15));
        end
        if (dc_ready || !dc_req) begin
          dc_req   = dc_ready ? ($urandom_range(0, 1) == 1)
                              : ($urandom_range(0, 2) == 0);
          dc_wen   = $urandom_range(0, 1) == 1;
          dc_addr  = 28'($urandom_range(0, 15));
          dc_wdata = {4{$urandom}};
        end else if (owner == 2 && $urandom_range(0, 3) == 0) begin
          dc_addr  = 28'($urandom_range(0, 15));
          dc_wdata = {4{$urandom}};
        end
        p_ic     = ic_req;
        p_dc     = dc_req;
        p_dwen   = dc_wen;
        p_mrdy   = mem_ready;
        p_iaddr  = ic_addr;
        p_daddr  = dc_addr;
        p_dwdata = dc_wdata;
        tick();
        cyc++;
        e_ir = 1'b0;
        e_dr = 1'b0;
        if (owner == 0) begin
          if (cyc >= next_ok && (p_ic || p_dc)) begin
            win   = (p_ic && p_dc) ? ((last == 1) ? 2 : 1) : (p_dc ? 2 : 1);
            owner = win;
            last  = win;
            if (win == 1) begin
              x_wr    = 1'b0;
              x_addr  = p_iaddr;
              x_wdata = '0;
            end else begin
              x_wr    = p_dwen;
              x_addr  = p_daddr;
              x_wdata = p_dwdata;
            end
          end
        end else if (p_mrdy) begin
          e_ir = (owner == 1);
          e_dr = (owner == 2);
          if (e_ir)
            check("rnd_ic_rdata", ic_rdata, ref_mem[x_addr[3:0]]);
          if (e_dr && !x_wr)
            check("rnd_dc_rdata", dc_rdata, ref_mem[x_addr[3:0]]);
          if (x_wr)
            ref_mem[x_addr[3:0]] = x_wdata;
          owner   = 0;
          next_ok = cyc + 2;
        end
        check("rnd_mem_read", mem_read, owner != 0 && !x_wr);
        check("rnd_mem_write", mem_write, owner != 0 && x_wr);
        check("rnd_ic_ready", ic_ready, e_ir);
        check("rnd_dc_ready", dc_ready, e_dr);
        if (owner != 0)
          check("rnd_mem_addr", mem_addr, x_addr);
        if (owner != 0 && x_wr)
          check("rnd_mem_wdata", mem_wdata, x_wdata);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
